// File: rtl/ft_cmd_parser.sv
// Purpose: parse 5-byte framed register commands (SYNC, CMD, ARG_HI, ARG_LO, CSUM) from the FT245 byte stream.
// Latency: strobes and register outputs appear one clock after the CSUM byte, or one clock after an inter-byte timeout.
// Backpressure: none; bytes are consumed whenever data_from_ft_avail is high and the parser never stalls the source.
module ft_cmd_parser #(
    parameter logic [7:0]  SYNC_BYTE = 8'hA5,
    parameter int unsigned TIMEOUT   = 1024
) (
    input  logic        ft_clkout,
    input  logic        rst,
    input  logic [7:0]  data_from_ft,
    input  logic        data_from_ft_avail,
    output logic [6:0]  reg_addr,
    output logic [15:0] reg_wdata,
    output logic        reg_we,
    output logic        cmd_ok,
    output logic        rd_req,
    output logic        cmd_err,
    output logic [7:0]  err_count
);

    // Counter only has to reach TIMEOUT-1, so clog2(TIMEOUT) bits suffice.
    localparam int unsigned TW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        GET_CMD  = 3'd1,
        GET_HI   = 3'd2,
        GET_LO   = 3'd3,
        GET_CSUM = 3'd4
    } state_t;

    state_t        state_q,     state_d;
    logic [TW-1:0] tmo_q,       tmo_d;
    logic [7:0]    cmd_q,       cmd_d;
    logic [7:0]    hi_q,        hi_d;
    logic [7:0]    lo_q,        lo_d;
    logic [6:0]    reg_addr_q,  reg_addr_d;
    logic [15:0]   reg_wdata_q, reg_wdata_d;
    logic          reg_we_q,    reg_we_d;
    logic          cmd_ok_q,    cmd_ok_d;
    logic          rd_req_q,    rd_req_d;
    logic          cmd_err_q,   cmd_err_d;
    logic [7:0]    err_count_q, err_count_d;

    logic byte_vld;
    logic csum_ok;
    logic timeout_hit;

    assign byte_vld    = data_from_ft_avail;
    assign csum_ok     = (data_from_ft == (cmd_q ^ hi_q ^ lo_q));
    // A byte in the same cycle as the last allowed idle count keeps the frame alive.
    assign timeout_hit = (state_q != IDLE) && !byte_vld && (tmo_q == TMO_LAST);

    // Next-state, shadow capture, timeout tracking and registered strobe generation.
    always_comb begin
        state_d     = state_q;
        tmo_d       = tmo_q;
        cmd_d       = cmd_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        reg_addr_d  = reg_addr_q;
        reg_wdata_d = reg_wdata_q;
        reg_we_d    = 1'b0;
        cmd_ok_d    = 1'b0;
        rd_req_d    = 1'b0;
        cmd_err_d   = 1'b0;
        err_count_d = err_count_q;

        case (state_q)
            IDLE: begin
                // Anything but the sync marker is line noise and is dropped quietly.
                if (byte_vld && (data_from_ft == SYNC_BYTE)) begin
                    state_d = GET_CMD;
                end
            end
            GET_CMD: begin
                if (byte_vld) begin
                    cmd_d   = data_from_ft;
                    state_d = GET_HI;
                end
            end
            GET_HI: begin
                if (byte_vld) begin
                    hi_d    = data_from_ft;
                    state_d = GET_LO;
                end
            end
            GET_LO: begin
                if (byte_vld) begin
                    lo_d    = data_from_ft;
                    state_d = GET_CSUM;
                end
            end
            GET_CSUM: begin
                if (byte_vld) begin
                    state_d = IDLE;
                    if (csum_ok) begin
                        reg_addr_d  = cmd_q[6:0];
                        reg_wdata_d = {hi_q, lo_q};
                        cmd_ok_d    = 1'b1;
                        reg_we_d    = ~cmd_q[7];
                        rd_req_d    = cmd_q[7];
                    end else begin
                        cmd_err_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Inter-byte watchdog: idle in IDLE, restarts on every byte inside a frame.
        if (state_q == IDLE) begin
            tmo_d = '0;
        end else if (byte_vld) begin
            tmo_d = '0;
        end else if (timeout_hit) begin
            tmo_d     = '0;
            state_d   = IDLE;
            cmd_err_d = 1'b1;
        end else begin
            tmo_d = tmo_q + TW'(1);
        end

        // Error counter moves in the same edge as the cmd_err pulse and sticks at 255.
        if (cmd_err_d && (err_count_q != 8'hFF)) begin
            err_count_d = err_count_q + 8'd1;
        end
    end

    // State, shadow and output registers with asynchronous reset.
    always_ff @(posedge ft_clkout or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            tmo_q       <= '0;
            cmd_q       <= 8'h00;
            hi_q        <= 8'h00;
            lo_q        <= 8'h00;
            reg_addr_q  <= 7'h00;
            reg_wdata_q <= 16'h0000;
            reg_we_q    <= 1'b0;
            cmd_ok_q    <= 1'b0;
            rd_req_q    <= 1'b0;
            cmd_err_q   <= 1'b0;
            err_count_q <= 8'h00;
        end else begin
            state_q     <= state_d;
            tmo_q       <= tmo_d;
            cmd_q       <= cmd_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            reg_addr_q  <= reg_addr_d;
            reg_wdata_q <= reg_wdata_d;
            reg_we_q    <= reg_we_d;
            cmd_ok_q    <= cmd_ok_d;
            rd_req_q    <= rd_req_d;
            cmd_err_q   <= cmd_err_d;
            err_count_q <= err_count_d;
        end
    end

    assign reg_addr  = reg_addr_q;
    assign reg_wdata = reg_wdata_q;
    assign reg_we    = reg_we_q;
    assign cmd_ok    = cmd_ok_q;
    assign rd_req    = rd_req_q;
    assign cmd_err   = cmd_err_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_ft_cmd_parser.sv
// Purpose: self-checking bench for ft_cmd_parser with a frame-level reference model and a strobe scoreboard.
// Latency: expects each accept/reject strobe exactly one clock after the deciding byte or idle cycle.
// Backpressure: none; the bench drives one byte or idle per clock.
module tb_ft_cmd_parser;

    localparam logic [7:0] SYNC = 8'hA5;
    localparam int         TMO  = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  data = 8'h00;
    logic        avail = 1'b0;
    logic [6:0]  reg_addr;
    logic [15:0] reg_wdata;
    logic        reg_we, cmd_ok, rd_req, cmd_err;
    logic [7:0]  err_count;

    ft_cmd_parser #(.SYNC_BYTE(SYNC), .TIMEOUT(TMO)) dut (
        .ft_clkout          (clk),
        .rst                (rst),
        .data_from_ft       (data),
        .data_from_ft_avail (avail),
        .reg_addr           (reg_addr),
        .reg_wdata          (reg_wdata),
        .reg_we             (reg_we),
        .cmd_ok             (cmd_ok),
        .rd_req             (rd_req),
        .cmd_err            (cmd_err),
        .err_count          (err_count)
    );

    always #8 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [31:0] due;
        logic        is_err;
        logic        is_rd;
        logic [6:0]  addr;
        logic [15:0] wdata;
        logic [7:0]  ec;
    } ev_t;

    ev_t sbq[$];
    int  checks = 0;
    int  errors = 0;

    // Reference model: bytes collected for the frame in progress, idle run length, visible register state.
    logic [7:0]  m_buf[$];
    int          m_idle = 0;
    logic [6:0]  m_addr = 7'h00;
    logic [15:0] m_wdata = 16'h0000;
    int          m_ec = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_ev(input bit is_err, input bit is_rd);
        ev_t e;
        e.due    = cyc + 1;
        e.is_err = is_err;
        e.is_rd  = is_rd;
        e.addr   = m_addr;
        e.wdata  = m_wdata;
        e.ec     = 8'(m_ec);
        sbq.push_back(e);
    endtask

    task automatic model_step(input bit v, input logic [7:0] b);
        logic [7:0] c, h, l, s;
        if (m_buf.size() == 0) begin
            if (v && b == SYNC) m_buf.push_back(b);
            m_idle = 0;
        end else if (v) begin
            m_buf.push_back(b);
            m_idle = 0;
            if (m_buf.size() == 5) begin
                c = m_buf[1]; h = m_buf[2]; l = m_buf[3]; s = m_buf[4];
                if ((c ^ h ^ l) == s) begin
                    m_addr  = c[6:0];
                    m_wdata = {h, l};
                    push_ev(1'b0, c[7]);
                end else begin
                    m_ec = (m_ec < 255) ? m_ec + 1 : 255;
                    push_ev(1'b1, 1'b0);
                end
                m_buf.delete();
            end
        end else begin
            m_idle++;
            if (m_idle == TMO) begin
                m_ec = (m_ec < 255) ? m_ec + 1 : 255;
                push_ev(1'b1, 1'b0);
                m_buf.delete();
                m_idle = 0;
            end
        end
    endtask

    task automatic drive_cycle(input bit v, input logic [7:0] b);
        @(negedge clk);
        avail = v;
        data  = v ? b : 8'($urandom);
        model_step(v, b);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive_cycle(1'b0, 8'h00);
    endtask

    task automatic send5(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                         input logic [7:0] b3, input logic [7:0] b4);
        drive_cycle(1'b1, b0);
        drive_cycle(1'b1, b1);
        drive_cycle(1'b1, b2);
        drive_cycle(1'b1, b3);
        drive_cycle(1'b1, b4);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst   = 1'b1;
        avail = 1'b0;
        m_buf.delete();
        m_idle  = 0;
        m_addr  = 7'h00;
        m_wdata = 16'h0000;
        m_ec    = 0;
        repeat (2) @(negedge clk);
        chk("rst_reg_addr",  32'(reg_addr),  32'h0);
        chk("rst_reg_wdata", 32'(reg_wdata), 32'h0);
        chk("rst_strobes",   32'({reg_we, cmd_ok, rd_req, cmd_err}), 32'h0);
        chk("rst_err_count", 32'(err_count), 32'h0);
        rst = 1'b0;
    endtask

    // Monitor: every presented strobe must match the oldest expected event, on its due cycle.
    initial begin
        ev_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (cmd_ok | cmd_err | reg_we | rd_req) begin
                    if (sbq.size() == 0) begin
                        chk("unexpected_strobe", 32'({reg_we, cmd_ok, rd_req, cmd_err}), 32'h0);
                    end else begin
                        e = sbq.pop_front();
                        chk("ev_cycle",     32'(cyc),       e.due);
                        chk("ev_cmd_ok",    32'(cmd_ok),    32'(!e.is_err));
                        chk("ev_cmd_err",   32'(cmd_err),   32'(e.is_err));
                        chk("ev_reg_we",    32'(reg_we),    32'(!e.is_err && !e.is_rd));
                        chk("ev_rd_req",    32'(rd_req),    32'(!e.is_err && e.is_rd));
                        chk("ev_reg_addr",  32'(reg_addr),  32'(e.addr));
                        chk("ev_reg_wdata", 32'(reg_wdata), 32'(e.wdata));
                        chk("ev_err_count", 32'(err_count), 32'(e.ec));
                    end
                end else if (sbq.size() > 0 && sbq[0].due <= cyc) begin
                    e = sbq.pop_front();
                    chk("missing_strobe_due", 32'(cyc), 32'(e.due - 1));
                end
            end
        end
    end

    initial begin
        logic [7:0] c, h, l, s;
        int gap;

        do_reset();

        // Write frame.
        send5(SYNC, 8'h03, 8'h12, 8'h34, 8'h25);
        drive_cycle(1'b0, 8'h00);
        chk("wr_reg_we",    32'(reg_we),    32'h1);
        chk("wr_cmd_ok",    32'(cmd_ok),    32'h1);
        chk("wr_reg_addr",  32'(reg_addr),  32'h03);
        chk("wr_reg_wdata", 32'(reg_wdata), 32'h1234);
        drive_cycle(1'b0, 8'h00);
        chk("wr_we_one_cycle", 32'(reg_we), 32'h0);

        // Read frame.
        send5(SYNC, 8'h85, 8'h00, 8'h00, 8'h85);
        drive_cycle(1'b0, 8'h00);
        chk("rd_rd_req",   32'(rd_req),   32'h1);
        chk("rd_cmd_ok",   32'(cmd_ok),   32'h1);
        chk("rd_reg_we",   32'(reg_we),   32'h0);
        chk("rd_reg_addr", 32'(reg_addr), 32'h05);
        chk("rd_reg_wdata", 32'(reg_wdata), 32'h0000);

        // Bad checksum.
        send5(SYNC, 8'h03, 8'h12, 8'h34, 8'h00);
        drive_cycle(1'b0, 8'h00);
        chk("bad_cmd_err",   32'(cmd_err),   32'h1);
        chk("bad_err_count", 32'(err_count), 32'h1);
        chk("bad_addr_hold", 32'(reg_addr),  32'h05);
        chk("bad_wdata_hold", 32'(reg_wdata), 32'h0000);
        drive_cycle(1'b0, 8'h00);
        chk("bad_err_one_cycle", 32'(cmd_err), 32'h0);

        // Timeout after two bytes, then a normal frame.
        drive_cycle(1'b1, SYNC);
        drive_cycle(1'b1, 8'h03);
        idle(TMO);
        drive_cycle(1'b0, 8'h00);
        chk("tmo_cmd_err",   32'(cmd_err),   32'h1);
        chk("tmo_err_count", 32'(err_count), 32'h2);
        drive_cycle(1'b0, 8'h00);
        chk("tmo_err_one_cycle", 32'(cmd_err), 32'h0);
        send5(SYNC, 8'h81, 8'hAB, 8'hCD, 8'hE7);
        drive_cycle(1'b0, 8'h00);
        chk("post_tmo_rd_req", 32'(rd_req),    32'h1);
        chk("post_tmo_wdata",  32'(reg_wdata), 32'hABCD);

        // Bytes landing on the last allowed idle cycle keep the frame alive.
        drive_cycle(1'b1, SYNC);
        drive_cycle(1'b1, 8'h02);
        idle(TMO - 1);
        drive_cycle(1'b1, 8'h00);
        idle(TMO - 1);
        drive_cycle(1'b1, 8'h07);
        drive_cycle(1'b1, 8'h05);
        drive_cycle(1'b0, 8'h00);
        chk("edge_reg_we",    32'(reg_we),    32'h1);
        chk("edge_reg_wdata", 32'(reg_wdata), 32'h0007);
        chk("edge_err_count", 32'(err_count), 32'h2);

        // Noise, partial frame cut by reset, then a clean write.
        drive_cycle(1'b1, 8'h00);
        drive_cycle(1'b1, 8'hFF);
        drive_cycle(1'b1, SYNC);
        drive_cycle(1'b1, 8'h01);
        do_reset();
        send5(SYNC, 8'h01, 8'h00, 8'h02, 8'h03);
        drive_cycle(1'b0, 8'h00);
        chk("noise_reg_we",    32'(reg_we),    32'h1);
        chk("noise_reg_addr",  32'(reg_addr),  32'h01);
        chk("noise_reg_wdata", 32'(reg_wdata), 32'h0002);
        chk("noise_err_count", 32'(err_count), 32'h0);

        // Back-to-back frames with a sync byte as payload.
        send5(SYNC, 8'h04, SYNC, 8'h01, 8'h04 ^ SYNC ^ 8'h01);
        send5(SYNC, 8'hA5, 8'h00, 8'h02, 8'hA7);
        idle(3);

        // Randomized frames, noise, gaps and corrupted checksums.
        for (int f = 0; f < 150; f++) begin
            for (int n = 0; n < int'($urandom_range(0, 2)); n++) drive_cycle(1'b1, 8'($urandom));
            c = 8'($urandom); h = 8'($urandom); l = 8'($urandom);
            s = c ^ h ^ l;
            if ($urandom_range(0, 3) == 0) s = s ^ 8'(1 << $urandom_range(0, 7));
            for (int k = 0; k < 5; k++) begin
                case (k)
                    0: drive_cycle(1'b1, SYNC);
                    1: drive_cycle(1'b1, c);
                    2: drive_cycle(1'b1, h);
                    3: drive_cycle(1'b1, l);
                    default: drive_cycle(1'b1, s);
                endcase
                gap = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, TMO + 1)) : 0;
                idle(gap);
            end
            idle(int'($urandom_range(0, 3)));
        end
        idle(TMO + 2);

        // Error counter saturation.
        do_reset();
        for (int f = 0; f < 300; f++) begin
            c = 8'($urandom); h = 8'($urandom); l = 8'($urandom);
            send5(SYNC, c, h, l, (c ^ h ^ l) ^ 8'h5A);
        end
        idle(2);
        chk("sat_err_count", 32'(err_count), 32'd255);
        send5(SYNC, 8'h10, 8'h20, 8'h30, 8'h00);
        idle(2);
        chk("sat_err_count_held", 32'(err_count), 32'd255);

        idle(4);
        chk("scoreboard_drained", 32'(sbq.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
